toggle_pulse_rx: RTL and testbench

//  Receive end of the toggle (mod-2) interface. A remote divide-by-2 flop

---
 rtl/toggle_pulse_rx_if.sv | 22 ++
 rtl/toggle_pulse_rx.sv | 121 ++++++++++++
 tb/tb_toggle_pulse_rx.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/toggle_pulse_rx_if.sv
// Toggle-line receiver bundle: remote toggle plus local clear in; decoded pulse, level, count and status out.
interface toggle_pulse_rx_if #(
    parameter int CNT_W = 8
);
    logic             tog_in;
    logic             clr;
    logic             pulse;
    logic             level;
    logic [CNT_W-1:0] cnt;
    logic             sat;
    logic             stall;

    modport master (
        output tog_in, clr,
        input  pulse, level, cnt, sat, stall
    );

    modport slave (
        input  tog_in, clr,
        output pulse, level, cnt, sat, stall
    );
endinterface

// File: rtl/toggle_pulse_rx.sv
// Toggle-link receiver: synchronises tog_in, emits one pulse per transition, counts events, flags a stalled link.
// Pulse is registered one clk after level changes; no backpressure, events are never held off.
module toggle_pulse_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8,
    parameter int TIMEOUT     = 16
) (
    input  logic               clk,
    input  logic               rst,
    toggle_pulse_rx_if.slave   bus
);
    localparam int IW = $clog2(SYNC_STAGES + 1);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {INIT, WAIT, ACTIVE, STALLED} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   pulse_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   sat_q;
    logic [TW-1:0]          idle_q, idle_d;
    logic [IW-1:0]          init_q, init_d;
    logic                   level;
    logic                   evt;

    assign level = sync_q[SYNC_STAGES-1];
    assign evt   = (state_q != INIT) && (level != prev_q);

    // INIT stays until the post-reset zeros have left the synchroniser, so a line
    // already high at release is absorbed into prev instead of decoding as an event.
    always_comb begin
        state_d = state_q;
        idle_d  = idle_q;
        init_d  = init_q;
        case (state_q)
            INIT: begin
                init_d = init_q + IW'(1);
                if (init_q == IW'(SYNC_STAGES)) begin
                    state_d = WAIT;
                    init_d  = '0;
                end
            end
            WAIT: begin
                if (evt) begin
                    state_d = ACTIVE;
                    idle_d  = '0;
                end
            end
            ACTIVE: begin
                if (evt) begin
                    idle_d = '0;
                end else if (idle_q == TW'(TIMEOUT - 1)) begin
                    state_d = STALLED;
                    idle_d  = '0;
                end else begin
                    idle_d = idle_q + TW'(1);
                end
            end
            STALLED: begin
                if (evt) begin
                    state_d = ACTIVE;
                    idle_d  = '0;
                end
            end
            default: begin
                state_d = INIT;
                idle_d  = '0;
                init_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= INIT;
            idle_q  <= '0;
            init_q  <= '0;
        end else begin
            state_q <= state_d;
            idle_q  <= idle_d;
            init_q  <= init_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.tog_in};
            prev_q  <= level;
            pulse_q <= evt;
        end
    end

    // clr beats a coincident event: the pulse still fires but is not counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else if (bus.clr) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else if (evt) begin
            if (cnt_q == '1) begin
                sat_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.pulse = pulse_q;
    assign bus.level = level;
    assign bus.cnt   = cnt_q;
    assign bus.sat   = sat_q;
    assign bus.stall = (state_q == STALLED);
endmodule

// File: tb/tb_toggle_pulse_rx.sv
// Directed bench for toggle_pulse_rx: reset, latency, counting, saturation, stall and clear/reset interactions.
module tb_toggle_pulse_rx;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    int   pcnt  = 0;
    int   p0;

    toggle_pulse_rx_if #(.CNT_W(4)) bus();

    toggle_pulse_rx #(
        .SYNC_STAGES (2),
        .CNT_W       (4),
        .TIMEOUT     (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.pulse === 1'b1) pcnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic flip_wait(input int gap);
        bus.tog_in = !bus.tog_in;
        cyc(gap);
    endtask

    task automatic clear();
        bus.clr = 1'b1;
        cyc(1);
        bus.clr = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        bus.tog_in = 1'b1;
        bus.clr    = 1'b0;
        cyc(3);
        check("rst_pulse", 32'(bus.pulse), 0);
        check("rst_level", 32'(bus.level), 0);
        check("rst_cnt",   32'(bus.cnt),   0);
        check("rst_sat",   32'(bus.sat),   0);
        check("rst_stall", 32'(bus.stall), 0);

        // line already high at release must not decode as an event
        rst = 1'b0;
        p0  = pcnt;
        cyc(10);
        check("t1_nopulse", 32'(pcnt - p0), 0);
        check("t1_cnt",     32'(bus.cnt),   0);
        check("t1_stall",   32'(bus.stall), 0);
        check("t1_level",   32'(bus.level), 1);

        flip_wait(6);
        check("t2_pre_cnt", 32'(bus.cnt), 1);
        clear();
        check("t2_clr_cnt", 32'(bus.cnt), 0);
        bus.tog_in = 1'b1;
        cyc(1);
        check("t2_k_pulse",  32'(bus.pulse), 0);
        cyc(1);
        check("t2_k1_pulse", 32'(bus.pulse), 0);
        check("t2_k1_level", 32'(bus.level), 1);
        cyc(1);
        check("t2_k2_pulse", 32'(bus.pulse), 1);
        check("t2_k2_cnt",   32'(bus.cnt),   1);
        cyc(1);
        check("t2_k3_pulse", 32'(bus.pulse), 0);

        clear();
        p0 = pcnt;
        for (int i = 0; i < 10; i++) begin
            bus.tog_in = !bus.tog_in;
            cyc(1);
            check("t3_level_old", 32'(bus.level), 32'(!bus.tog_in));
            cyc(1);
            check("t3_level_new", 32'(bus.level), 32'(bus.tog_in));
            cyc(2);
        end
        check("t3_pulses", 32'(pcnt - p0), 10);
        check("t3_cnt",    32'(bus.cnt),   10);

        clear();
        repeat (15) flip_wait(4);
        check("t4_cnt_at_max", 32'(bus.cnt), 15);
        check("t4_sat_at_max", 32'(bus.sat), 0);
        repeat (2) flip_wait(4);
        check("t4_cnt_hold", 32'(bus.cnt), 15);
        check("t4_sat",      32'(bus.sat), 1);
        clear();
        check("t4_clr_cnt", 32'(bus.cnt), 0);
        check("t4_clr_sat", 32'(bus.sat), 0);

        flip_wait(4);
        flip_wait(4);
        bus.tog_in = !bus.tog_in;
        cyc(3);
        check("t5_pulse", 32'(bus.pulse), 1);
        check("t5_cnt",   32'(bus.cnt),   3);
        cyc(15);
        check("t5_stall_early", 32'(bus.stall), 0);
        cyc(1);
        check("t5_stall", 32'(bus.stall), 1);
        bus.tog_in = !bus.tog_in;
        cyc(2);
        check("t5_stall_hold", 32'(bus.stall), 1);
        check("t5_pulse_hold", 32'(bus.pulse), 0);
        cyc(1);
        check("t5_stall_drop", 32'(bus.stall), 0);
        check("t5_pulse_rise", 32'(bus.pulse), 1);
        check("t5_cnt_resume", 32'(bus.cnt),   4);

        cyc(1);
        bus.tog_in = !bus.tog_in;
        cyc(2);
        bus.clr = 1'b1;
        cyc(1);
        bus.clr = 1'b0;
        check("t6_clr_pulse", 32'(bus.pulse), 1);
        check("t6_clr_cnt",   32'(bus.cnt),   0);
        cyc(1);
        flip_wait(4);
        flip_wait(4);
        check("t6_cnt2", 32'(bus.cnt), 2);
        bus.tog_in = !bus.tog_in;
        cyc(3);
        check("t6_pre_rst_pulse", 32'(bus.pulse), 1);
        #1 rst = 1'b1;
        #1;
        check("t6_arst_pulse", 32'(bus.pulse), 0);
        check("t6_arst_level", 32'(bus.level), 0);
        check("t6_arst_cnt",   32'(bus.cnt),   0);
        check("t6_arst_sat",   32'(bus.sat),   0);
        check("t6_arst_stall", 32'(bus.stall), 0);
        cyc(1);
        rst = 1'b0;
        p0  = pcnt;
        cyc(6);
        check("t6_reinit_nopulse", 32'(pcnt - p0), 0);
        flip_wait(4);
        check("t6_restart_cnt", 32'(bus.cnt), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
